// File: rtl/load_store_unit.sv
// Multi-cycle load/store initiator for a word-addressed data memory with sub-word RMW stores and load extension.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned or reserved-size requests return resp_err without touching memory.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid-side payload is held until that edge, ready never depends on valid.
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              uns_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;
    logic [31:0]       rdata_q;
    logic              accept;
    logic              req_bad;

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] a, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] sz, input logic [1:0] a);
        logic [31:0] r;
        r = w;
        case (sz)
            2'b00: r[{a, 3'b000} +: 8] = d[7:0];
            2'b01: if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q;
    assign req_bad = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
    assign req_bad = 1'b0;
`endif

    assign accept = req_valid && (state == IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad)                     state_next = RESP;
                    else if (req_we && req_size[1])  state_next = WRITE;
                    else                             state_next = READ;
                end
            end
            READ:    state_next = we_q ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            size_q  <= 2'b00;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= 32'h0;
            word_q  <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata;
                rdata_q <= 32'h0;
            end
            if (state == READ) begin
                word_q <= mem_rdata;
                if (!we_q) rdata_q <= extend(mem_rdata, size_q, addr_q[1:0], uns_q);
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset)       err_q <= 1'b0;
        else if (accept) err_q <= req_bad;
    end
    assign resp_err = resp_valid && err_q;
`else
    assign resp_err = 1'b0;
`endif

    // Outputs are forced quiet during the reset cycle even if the state register is mid-operation.
    assign req_ready  = (state == IDLE);
    assign mem_read   = (state == READ) && !reset;
    assign mem_write  = (state == WRITE) && !reset;
    assign resp_valid = (state == RESP) && !reset;
    assign resp_rdata = resp_valid ? rdata_q : 32'h0;
    assign mem_addr   = reset ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata  = mem_write ? merge(word_q, wdata_q, size_q, addr_q[1:0]) : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random traffic against a byte-level reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];

    int          op_lat, op_reads, op_writes;
    logic [31:0] op_rdata, op_wdata, op_raddr;
    logic        op_err;
    int          exp_lat, exp_reads, exp_writes;
    logic [31:0] exp_rdata, exp_wdata;
    logic        exp_err;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // clock / memory
    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

    // reference model: byte arithmetic on a word array
    function automatic logic ref_trap(input logic [1:0] size, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
        return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns, input logic [31:0] addr);
        logic [31:0] w, v;
        w = ref_mem[addr[9:2]];
        if (size == 2'd0) begin
            v = (w >> (8 * addr[1:0])) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (w >> (16 * addr[1])) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] d);
        logic [31:0] w, mask;
        w = ref_mem[addr[9:2]];
        if (size == 2'd0)      mask = 32'hFF << (8 * addr[1:0]);
        else if (size == 2'd1) mask = 32'hFFFF << (16 * addr[1]);
        else                   mask = 32'hFFFF_FFFF;
        if (size == 2'd0)      d = (d & 32'hFF) << (8 * addr[1:0]);
        else if (size == 2'd1) d = (d & 32'hFFFF) << (16 * addr[1]);
        return (w & ~mask) | (d & mask);
    endfunction

    // driver: one full request/response transaction, with predictions taken from the model first
    task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        int  n;
        bit  got;
        logic trap;
        trap       = ref_trap(size, addr);
        exp_err    = trap;
        exp_rdata  = (trap || we) ? 32'h0 : ref_load(size, uns, addr);
        exp_wdata  = ref_store(size, addr, wd);
        exp_lat    = trap ? 1 : (!we ? 2 : (size >= 2'd2 ? 2 : 3));
        exp_reads  = (trap || (we && size >= 2'd2)) ? 0 : 1;
        exp_writes = (!trap && we) ? 1 : 0;
        if (!trap && we) ref_mem[addr[9:2]] = exp_wdata;

        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        op_lat = 0; op_reads = 0; op_writes = 0; op_wdata = 32'h0; op_raddr = 32'h0;
        op_rdata = 32'hDEAD_BEEF; op_err = 1'bx; got = 0;
        while (!got && op_lat < 20) begin
            @(negedge clk);
            op_lat++;
            if (mem_read)  begin op_reads++;  op_raddr = mem_addr; end
            if (mem_write) begin op_writes++; op_wdata = mem_wdata; end
            if (resp_valid) begin got = 1; op_rdata = resp_rdata; op_err = resp_err; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
        mem[0] = 32'd4;  mem[1] = 32'd5;  mem[2] = 32'd10;  mem[4] = 32'd1;
        ref_mem[0] = 32'd4; ref_mem[1] = 32'd5; ref_mem[2] = 32'd10; ref_mem[4] = 32'd1;
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({mem_read, mem_write, resp_valid, resp_err} !== 4'b0 || mem_addr !== 32'h0 ||
            mem_wdata !== 32'h0 || resp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got rd=%b wr=%b rv=%b err=%b addr=%h wd=%h rdata=%h expected all zero",
                     mem_read, mem_write, resp_valid, resp_err, mem_addr, mem_wdata, resp_rdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_req_ready got %b expected 1", req_ready);
        end
    endtask

    task automatic test_word_load();
        do_op(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
        vectors++;
        if (op_reads !== 1 || op_raddr !== 32'h8) begin
            miscompares++;
            $display("FAIL lw_read_strobe got reads=%0d addr=%h expected 1 / 00000008", op_reads, op_raddr);
        end
        vectors++;
        if (op_lat !== 2 || op_rdata !== 32'h0000_000A) begin
            miscompares++;
            $display("FAIL lw_result got lat=%0d rdata=%h expected 2 / 0000000a", op_lat, op_rdata);
        end
    endtask

    task automatic test_misalign();
        do_op(1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        vectors++;
        if (op_err !== 1'b1 || op_rdata !== 32'h0 || op_lat !== 1 || op_reads !== 0) begin
            miscompares++;
            $display("FAIL misalign_trap got err=%b rdata=%h lat=%0d reads=%0d expected 1 / 0 / 1 / 0",
                     op_err, op_rdata, op_lat, op_reads);
        end
`else
        vectors++;
        if (op_err !== 1'b0 || op_rdata !== 32'h5 || op_raddr !== 32'h4) begin
            miscompares++;
            $display("FAIL misalign_align got err=%b rdata=%h addr=%h expected 0 / 00000005 / 00000004",
                     op_err, op_rdata, op_raddr);
        end
`endif
    endtask

    task automatic test_byte_store();
        do_op(1'b1, 2'd0, 1'b0, 32'h5, 32'h0000_00FF);
        vectors++;
        if (op_reads !== 1 || op_writes !== 1 || op_wdata !== 32'h0000_FF05 || op_lat !== 3 || op_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL sb_rmw got reads=%0d writes=%0d wdata=%h lat=%0d rdata=%h expected 1 / 1 / 0000ff05 / 3 / 0",
                     op_reads, op_writes, op_wdata, op_lat, op_rdata);
        end
        do_op(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
        vectors++;
        if (op_rdata !== 32'h0000_FF05) begin
            miscompares++; $display("FAIL sb_lw got %h expected 0000ff05", op_rdata);
        end
        do_op(1'b0, 2'd0, 1'b0, 32'h5, 32'h0);
        vectors++;
        if (op_rdata !== 32'hFFFF_FFFF) begin
            miscompares++; $display("FAIL sb_lb got %h expected ffffffff", op_rdata);
        end
        do_op(1'b0, 2'd0, 1'b1, 32'h5, 32'h0);
        vectors++;
        if (op_rdata !== 32'h0000_00FF) begin
            miscompares++; $display("FAIL sb_lbu got %h expected 000000ff", op_rdata);
        end
    endtask

    task automatic test_half_store();
        do_op(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_8001);
        vectors++;
        if (op_writes !== 1 || op_wdata !== 32'h8001_0001) begin
            miscompares++;
            $display("FAIL sh_rmw got writes=%0d wdata=%h expected 1 / 80010001", op_writes, op_wdata);
        end
        do_op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        vectors++;
        if (op_rdata !== 32'hFFFF_8001) begin
            miscompares++; $display("FAIL sh_lh got %h expected ffff8001", op_rdata);
        end
        do_op(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
        vectors++;
        if (op_rdata !== 32'h0000_8001) begin
            miscompares++; $display("FAIL sh_lhu got %h expected 00008001", op_rdata);
        end
    endtask

    task automatic test_backpressure();
        int n;
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
        vectors++;
        if (n !== 2) begin
            miscompares++; $display("FAIL bp_latency got %0d expected 2", n);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) resp_ready = 1'b1;
            vectors++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h4 || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d got rv=%b rdata=%h req_ready=%b expected 1 / 00000004 / 0",
                         i, resp_valid, resp_rdata, req_ready);
            end
            if (i < 3) @(negedge clk);
        end
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release got req_ready=%b rv=%b expected 1 / 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        int wr_seen;
        wr_seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h21; req_wdata = 32'hAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        if (mem_write) wr_seen++;
        vectors++;
        if ({mem_read, mem_write, resp_valid, resp_err} !== 4'b0 || mem_addr !== 32'h0 ||
            mem_wdata !== 32'h0 || resp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL midop_reset_outputs got rd=%b wr=%b rv=%b err=%b addr=%h wd=%h expected all zero",
                     mem_read, mem_write, resp_valid, resp_err, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        if (mem_write) wr_seen++;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++; $display("FAIL midop_req_ready got %b expected 1", req_ready);
        end
        @(negedge clk);
        if (mem_write) wr_seen++;
        vectors++;
        if (wr_seen !== 0) begin
            miscompares++; $display("FAIL midop_no_write got %0d write cycles expected 0", wr_seen);
        end
        do_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        vectors++;
        if (op_rdata !== 32'h0) begin
            miscompares++; $display("FAIL midop_word_unchanged got %h expected 00000000", op_rdata);
        end
    endtask

    task automatic test_random();
        logic        we, uns;
        logic [1:0]  size;
        logic [31:0] addr, wd;
        for (int i = 0; i < 60; i++) begin
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            addr = 32'($urandom_range(0, 63));
            wd   = $urandom;
            do_op(we, size, uns, addr, wd);
            vectors++;
            if (op_rdata !== exp_rdata || op_err !== exp_err || op_lat !== exp_lat) begin
                miscompares++;
                $display("FAIL rand_resp #%0d we=%b sz=%0d a=%h got rdata=%h err=%b lat=%0d expected %h / %b / %0d",
                         i, we, size, addr, op_rdata, op_err, op_lat, exp_rdata, exp_err, exp_lat);
            end
            vectors++;
            if (op_reads !== exp_reads || op_writes !== exp_writes || (exp_writes == 1 && op_wdata !== exp_wdata)) begin
                miscompares++;
                $display("FAIL rand_mem #%0d we=%b sz=%0d a=%h got reads=%0d writes=%0d wdata=%h expected %0d / %0d / %h",
                         i, we, size, addr, op_reads, op_writes, op_wdata, exp_reads, exp_writes, exp_wdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_misalign();
        test_byte_store();
        test_half_store();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle load/store initiator between the CPU datapath and the word-addressed data memory (256 x 32, combinational read, posedge write).
- Accepts byte/halfword/word load and store requests over a valid/ready handshake and issues mem_read/mem_write with a word-aligned address.
- Performs read-modify-write for sub-word stores and sign/zero extension for sub-word loads.
- Returns results over a valid/ready response channel.

Parameters:
- ADDR_W, 32, width of the request and memory address.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  CPU request valid
- req_ready  output  1  unit can accept a request
- req_we  input  1  1=store, 0=load
- req_size  input  2  00=byte, 01=half, 10=word, 11=reserved
- req_unsigned  input  1  load zero-extends when 1
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  response valid
- resp_ready  input  1  CPU accepts response
- resp_rdata  output  32  extended load data; 0 for stores
- resp_err  output  1  access fault (only with the optional feature)
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_addr  output  ADDR_W  {addr[ADDR_W-1:2],2'b00}
- mem_wdata  output  32  word to write
- mem_rdata  input  32  memory read data, valid in the same cycle as mem_read

Behaviour:
- States: IDLE, READ, WRITE, RESP. The state register is the only source of the strobes:
  - mem_read = (state==READ)
  - mem_write = (state==WRITE)
  - req_ready = (state==IDLE)
- Reset (synchronous, any state, including mid-operation):
  - state goes to IDLE and the pending request is dropped.
  - During the reset cycle: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready=1 in the first cycle after reset.
- Acceptance: in IDLE, req_valid&&req_ready registers addr, size, we, unsigned and wdata. No request is captured outside IDLE.
- Next state from IDLE:
  - Load: READ.
  - Word store: WRITE.
  - Sub-word store: READ.
- READ:
  - mem_rdata is captured at the end of the cycle.
  - Loads go to RESP; sub-word stores go to WRITE.
- WRITE:
  - Word store: mem_wdata = wdata.
  - Byte store: captured word with lane addr[1:0] replaced by wdata[7:0].
  - Half store: captured word with lane addr[1] (bits [15:0] or [31:16]) replaced by wdata[15:0].
  - Then go to RESP.
- RESP:
  - resp_valid=1 until resp_valid&&resp_ready, then IDLE.
  - resp_rdata and resp_err are held stable while resp_valid is high.
- Latency from acceptance to first resp_valid cycle:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Minimum request throughput is one request per 3 cycles (word ops), given resp_ready=1.
- Load extension:
  - Byte lane addr[1:0], half lane addr[1].
  - Sign-extended unless req_unsigned; req_unsigned is ignored for word loads.
- req_size=11 is treated as word when the optional feature is absent.
- Addresses: addr[1:0] never reaches mem_addr. Wrap-around beyond memory depth is the memory's concern; this unit does not bound-check.
- Back-to-back operation: a new request is only accepted in the cycle after a response handshake (IDLE).

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: misaligned accesses and req_size=11 go IDLE -> RESP directly.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - In this path: resp_err=1, resp_rdata=0, no mem_read/mem_write pulse. Latency is 1 cycle.
  - resp_err=0 for all legal accesses.
- Undefined:
  - resp_err is tied 0.
  - Misaligned half accesses use lane addr[1]; misaligned word accesses are force-aligned to addr & ~3.
  - req_size=11 behaves as word.

Test Plan:
1. Memory preloaded with word0=4, word1=5, word2=10, word4=1. LW addr 0x8 -> mem_read for exactly 1 cycle with mem_addr=0x8; resp_valid 2 cycles after acceptance with resp_rdata=0x0000000A.
2. SB wdata=0x000000FF addr 0x5 -> READ then WRITE with mem_wdata=0x0000FF05, resp_valid at cycle 3. Then LW 0x4 -> 0x0000FF05; LB 0x5 -> 0xFFFFFFFF; LBU 0x5 -> 0x000000FF.
3. SH wdata=0x8001 addr 0x12 (word4=1) -> mem_wdata=0x80010001. Then LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001.
4. LW 0x0 with resp_ready held low 3 cycles -> resp_valid high 4 cycles with resp_rdata=0x4 stable, req_ready=0 throughout; req_ready=1 the cycle after the handshake.
5. Sub-word store with reset asserted in its READ cycle -> no mem_write pulse, all outputs 0 during reset, req_ready=1 the next cycle; the memory word is unchanged on a subsequent LW.
6. LW addr 0x6:
   - With LSU_MISALIGN_TRAP_EN: resp_err=1 and resp_rdata=0 one cycle after acceptance, no mem_read.
   - Without it: mem_addr=0x4 and resp_rdata=0x5, resp_err=0.
